// File: rtl/alu.sv
// Registered RV32 integer ALU: a combinational op mux feeding one {overflow, sum} register stage.
// Define ALU_MUL_EN to add MUL (1100) and MULHU (1101); otherwise those codes act as reserved.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [3:0]       sub,
  input  logic             alu_enable,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] add_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_s;
  logic             add_ovf_s;
  logic             sub_ovf_s;
  logic             ovf_s;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod_s;
`endif

  assign shamt_s = r2[SHW-1:0];
  assign add_s   = r1 + r2;
  assign diff_s  = r1 - r2;

  // Overflow is judged on sign bits only, so it is valid for any WIDTH.
  assign add_ovf_s = (r1[WIDTH-1] == r2[WIDTH-1]) && (add_s[WIDTH-1] != r1[WIDTH-1]);
  assign sub_ovf_s = (r1[WIDTH-1] != r2[WIDTH-1]) && (diff_s[WIDTH-1] != r1[WIDTH-1]);

`ifdef ALU_MUL_EN
  assign prod_s = {{WIDTH{1'b0}}, r1} * {{WIDTH{1'b0}}, r2};
`endif

  // Result and overflow selection for the current op code
  always_comb begin
    result_s = {WIDTH{1'b0}};
    ovf_s    = 1'b0;
    case (sub)
      4'b0000: begin
        result_s = add_s;
        ovf_s    = add_ovf_s;
      end
      4'b0001: begin
        result_s = diff_s;
        ovf_s    = sub_ovf_s;
      end
      4'b0010: result_s = r1 & r2;
      4'b0011: result_s = r1 | r2;
      4'b0100: result_s = r1 ^ r2;
      4'b0101: result_s = r1 << shamt_s;
      4'b0110: result_s = {{(WIDTH-1){1'b0}}, ($signed(r1) < $signed(r2))};
      4'b0111: result_s = {{(WIDTH-1){1'b0}}, (r1 < r2)};
      4'b1000: result_s = $signed(r1) >>> shamt_s;
      4'b1001: result_s = r1 >> shamt_s;
      4'b1010: result_s = r2;
      4'b1011: result_s = {{(WIDTH-1){1'b0}}, (r1 == r2)};
`ifdef ALU_MUL_EN
      4'b1100: result_s = prod_s[WIDTH-1:0];
      4'b1101: result_s = prod_s[2*WIDTH-1:WIDTH];
`endif
      default: begin
        result_s = {WIDTH{1'b0}};
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Output register: reset wins over enable, disabled edges hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= {WIDTH{1'b0}};
      overflow <= 1'b0;
    end else if (alu_enable) begin
      sum      <= result_s;
      overflow <= ovf_s;
    end else begin
      sum      <= sum;
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps followed by randomized ops against
// an arithmetic reference model. Honours ALU_MUL_EN the same way as the design.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] r1;
  logic [31:0] r2;
  logic [3:0]  sub;
  logic        alu_enable;
  logic [31:0] sum;
  logic        overflow;

  int          n_checks;
  int          n_fail;
  logic [32:0] exp_r;
  logic [31:0] corner [5];

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .r1         (r1),
    .r2         (r2),
    .sub        (sub),
    .alu_enable (alu_enable),
    .sum        (sum),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {overflow, result} from plain 64-bit arithmetic
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          st;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned ut;
    int unsigned     sh;
    logic [31:0]     res;
    logic            ov;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sh  = {27'd0, b[4:0]};
    res = 32'd0;
    ov  = 1'b0;
    case (op)
      4'd0: begin ut = ua + ub; res = ut[31:0]; st = sa + sb; ov = (st > SMAX) || (st < SMIN); end
      4'd1: begin ut = ua - ub; res = ut[31:0]; st = sa - sb; ov = (st > SMAX) || (st < SMIN); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin ut = ua << sh; res = ut[31:0]; end
      4'd6: res = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: res = (ua < ub) ? 32'd1 : 32'd0;
      4'd8: begin st = sa >>> sh; res = st[31:0]; end
      4'd9: begin ut = ua >> sh; res = ut[31:0]; end
      4'd10: res = b;
      4'd11: res = (a == b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd12: begin ut = ua * ub; res = ut[31:0]; end
      4'd13: begin ut = ua * ub; res = ut[63:32]; end
`endif
      default: res = 32'd0;
    endcase
    return {ov, res};
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed ovf/sum %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one edge, update the expected register state and compare against the model
  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic en, input logic rs);
    r1 = a;
    r2 = b;
    sub = op;
    alu_enable = en;
    rst = rs;
    @(posedge clk);
    #1;
    if (rs) exp_r = 33'd0;
    else if (en) exp_r = model(op, a, b);
    check(tag, {overflow, sum}, exp_r);
  endtask

  // Same as step, plus a check against a hand-derived constant
  task automatic step_lit(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic en, input logic rs,
                          input logic [32:0] lit);
    step(tag, op, a, b, en, rs);
    check({tag, "_lit"}, {overflow, sum}, lit);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        en;
    logic        rs;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    alu_enable = 1'b0;
    r1 = 32'd0;
    r2 = 32'd0;
    sub = 4'd0;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'hFFFF_FFFF;
    #1;

    step_lit("reset", 4'd0, $urandom, $urandom, 1'b1, 1'b1, 33'd0);
    step_lit("idle0", 4'd0, 32'd5, 32'd3, 1'b0, 1'b0, 33'd0);
    step_lit("idle1", 4'd1, 32'd9, 32'd4, 1'b0, 1'b0, 33'd0);

    step_lit("srl8", 4'd9, 32'd8, 32'd1, 1'b1, 1'b0, {1'b0, 32'd4});
    step_lit("srl4", 4'd9, 32'd4, 32'd1, 1'b1, 1'b0, {1'b0, 32'd2});
    step_lit("srl2", 4'd9, 32'd2, 32'd1, 1'b1, 1'b0, {1'b0, 32'd1});
    step_lit("srl1", 4'd9, 32'd1, 32'd1, 1'b1, 1'b0, {1'b0, 32'd0});
    step_lit("sra", 4'd8, 32'h8000_0000, 32'd4, 1'b1, 1'b0, {1'b0, 32'hF800_0000});

    step_lit("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b0, {1'b1, 32'h8000_0000});
    step_lit("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, 1'b1, 1'b0, {1'b1, 32'h7FFF_FFFF});
    step_lit("add_5_3", 4'd0, 32'd5, 32'd3, 1'b1, 1'b0, {1'b0, 32'd8});

    step_lit("slt_m1_1", 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, {1'b0, 32'd1});
    step_lit("sltu_m1_1", 4'd7, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, {1'b0, 32'd0});
    step_lit("slt_min_0", 4'd6, 32'h8000_0000, 32'd0, 1'b1, 1'b0, {1'b0, 32'd1});
    step_lit("sltu_min_0", 4'd7, 32'h8000_0000, 32'd0, 1'b1, 1'b0, {1'b0, 32'd0});
    step_lit("eq_7_7", 4'd11, 32'd7, 32'd7, 1'b1, 1'b0, {1'b0, 32'd1});
    step_lit("and", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0, {1'b0, 32'hF000_F000});
    step_lit("or", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0, {1'b0, 32'hFFF0_FFF0});
    step_lit("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0, {1'b0, 32'h0FF0_0FF0});
    step_lit("passb", 4'd10, 32'h1234_5678, 32'hABCD_E000, 1'b1, 1'b0, {1'b0, 32'hABCD_E000});

    step_lit("sll_mask", 4'd5, 32'd1, 32'h21, 1'b1, 1'b0, {1'b0, 32'd2});
    for (int i = 0; i < 3; i++)
      step_lit("hold", 4'd0, $urandom, $urandom, 1'b0, 1'b0, {1'b0, 32'd2});
    step_lit("sll_zero", 4'd5, 32'hDEAD_BEEF, 32'h20, 1'b1, 1'b0, {1'b0, 32'hDEAD_BEEF});
    step_lit("reserved", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'd0);

    step_lit("add_pre", 4'd0, 32'd5, 32'd3, 1'b1, 1'b0, {1'b0, 32'd8});
    step_lit("mid_rst", 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 1'b1, 33'd0);

`ifdef ALU_MUL_EN
    step_lit("mul", 4'd12, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, {1'b0, 32'hFFFF_FFFE});
    step_lit("mulhu", 4'd13, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, {1'b0, 32'h0000_0001});
`else
    step_lit("mul_off", 4'd12, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 33'd0);
    step_lit("mulhu_off", 4'd13, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 33'd0);
`endif

    // Randomized ops mixing corner operands, idle edges and occasional resets
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      en = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 15) == 0);
      step("random", op, a, b, en, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered integer ALU for the RV32 core's execute stage.
- Computes one of the arithmetic, logic, shift or compare operations on two operands, selected by a 4-bit op code `sub`.
- Drives the result `sum` and a signed-overflow flag `overflow`; both are registered, one cycle after the inputs are sampled.
- Sits between the decode/operand-mux logic and writeback.

Parameters:
- WIDTH, 32, operand and result width. Shift amount is r2[SHW-1:0], where SHW = $clog2(WIDTH), so 5 bits at the default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- r1  input  WIDTH  operand A; the value shifted in shift ops.
- r2  input  WIDTH  operand B; also the shift amount for shift ops.
- sub  input  4  operation select (encoding under Behaviour).
- alu_enable  input  1  when high, operands are sampled and outputs update this edge.
- sum  output  WIDTH  registered result.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Reset: rst high at a rising edge sets sum=0 and overflow=0. rst takes priority over alu_enable. A reset mid-stream discards the in-flight result.
- Latency: 1 cycle. Inputs are sampled at edge N when alu_enable=1 and rst=0; the result is visible after edge N.
- alu_enable=0: sum and overflow hold their previous values.
- Back-to-back ops: each enabled edge produces an independent result. There is no pipeline state beyond the output registers.
- Op encoding (sub):
  - 0000 ADD: r1+r2, wraps modulo 2^WIDTH.
  - 0001 SUB: r1-r2, wraps modulo 2^WIDTH.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SLL: r1 << r2[SHW-1:0].
  - 0110 SLT: signed r1<r2 gives 1, else 0, zero-extended.
  - 0111 SLTU: unsigned compare, same output format as SLT.
  - 1000 SRA: arithmetic right shift; the sign bit is replicated.
  - 1001 SRL: logical right shift; zero fill.
  - 1010 PASSB: sum=r2 (LUI path).
  - 1011 EQ: 1 if r1==r2, else 0.
  - 1100/1101: MUL/MULHU, see Optional Feature.
  - 1110, 1111: reserved; sum=0.
- Shift rules: only the low SHW bits of r2 are used; upper bits are ignored. Shift by 0 returns r1 unchanged.
- overflow rules:
  - ADD: 1 when the operands have the same sign and the result sign differs.
  - SUB: 1 when the operands have different signs and the result sign differs from r1.
  - All other ops: 0.
- Signed boundaries: ADD 0x7FFFFFFF+1 wraps to 0x80000000. SUB 0x80000000-1 wraps to 0x7FFFFFFF. SLT of 0x80000000 vs 0 gives 1; SLTU of the same pair gives 0.
- Datapath: combinational result mux into one WIDTH+1 bit register stage. No X propagation: every op code, including reserved ones, resolves to a defined value.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - op 1100 MUL: sum = low WIDTH bits of r1*r2 (unsigned product; the low half is sign-agnostic).
  - op 1101 MULHU: sum = high WIDTH bits of the unsigned 2*WIDTH product.
  - overflow=0 for both ops.
  - Latency stays 1 cycle.
- Undefined: 1100 and 1101 behave as reserved (sum=0, overflow=0), and no multiplier is synthesised.

Test Plan:
- Reset: drive rst=1 for 1 edge with arbitrary inputs -> sum=0, overflow=0. Then rst=0, alu_enable=0 -> outputs stay 0.
- SRL sequence: sub=1001, r2=1, alu_enable=1; r1=8,4,2,1 on consecutive edges -> sum=4,2,1,0, each one cycle after the input. Also SRA on r1=0x80000000, r2=4 -> 0xF8000000.
- Arithmetic overflow:
  - ADD 0x7FFFFFFF+0x1 -> sum=0x80000000, overflow=1.
  - SUB 0x80000000-0x1 -> sum=0x7FFFFFFF, overflow=1.
  - ADD 5+3 -> sum=8, overflow=0.
- Compare/logic:
  - SLT(0xFFFFFFFF,1) -> 1; SLTU same -> 0.
  - EQ(7,7) -> 1.
  - AND/OR/XOR of 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
- Shift masking and hold:
  - SLL r1=1, r2=0x21 -> 2 (only r2[4:0]=1 is used).
  - Then alu_enable=0 with new inputs for 3 edges -> sum holds 2.
  - Reserved op 1111 -> sum=0.
- Mid-stream reset and optional multiply:
  - ADD enabled with rst=1 on the same edge -> sum=0.
  - With ALU_MUL_EN defined: MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same -> 0x00000001.
  - Without ALU_MUL_EN: both -> 0.
